// File: rtl/led_run_ctrl.sv
// Running-light sequencer: walks one lit LED across N_LED outputs, lit only in the tail of each step.
// Optional bounce (ping-pong) mode when LED_RUN_PINGPONG_EN is defined; wrap mode otherwise.
module led_run_ctrl #(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned T_STEP   = 20,
    parameter int unsigned ON_START = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Hold,
    input  logic             Dir,
    output logic [N_LED-1:0] LED_Out,
    output logic             Busy,
    output logic             Step_Done,
    output logic             Lap_Done
);

    localparam int unsigned CW = (T_STEP > 0) ? $clog2(T_STEP + 1) : 1;
    localparam int unsigned PW = $clog2(N_LED);

    localparam logic [CW-1:0] T_STEP_C   = CW'(T_STEP);
    localparam logic [CW-1:0] ON_START_C = CW'(ON_START);
    localparam logic [PW-1:0] POS_LAST   = PW'(N_LED - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      pos_q, pos_d;
    logic               rdir_q, rdir_d;
    logic [N_LED-1:0]   led_q, led_d;
    logic               step_q, step_d;
    logic               lap_q, lap_d;
    logic [N_LED-1:0]   pos_onehot;

    always_comb begin
        pos_onehot        = '0;
        pos_onehot[pos_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pos_d   = pos_q;
        rdir_d  = rdir_q;
        led_d   = led_q;
        step_d  = 1'b0;
        lap_d   = 1'b0;

        if (Stop) begin
            state_d = IDLE;
            count_d = '0;
            led_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    led_d   = '0;
                    if (Start && !Hold) begin
                        state_d = RUN;
                        pos_d   = Dir ? POS_LAST : '0;
                        rdir_d  = Dir;
                    end
                end
                RUN, HOLD: begin
                    if (Hold) begin
                        // Everything frozen; each held edge stretches the current step by one cycle.
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                        led_d   = (count_q >= ON_START_C) ? pos_onehot : '0;
                        if (count_q == T_STEP_C) begin
                            count_d = '0;
                            step_d  = 1'b1;
`ifdef LED_RUN_PINGPONG_EN
                            if (!rdir_q) begin
                                if (pos_q == POS_LAST) begin
                                    rdir_d = 1'b1;
                                    pos_d  = pos_q - PW'(1);
                                    lap_d  = 1'b1;
                                end else begin
                                    pos_d  = pos_q + PW'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    rdir_d = 1'b0;
                                    pos_d  = pos_q + PW'(1);
                                    lap_d  = 1'b1;
                                end else begin
                                    pos_d  = pos_q - PW'(1);
                                end
                            end
`else
                            if (!rdir_q) begin
                                if (pos_q == POS_LAST) begin
                                    pos_d = '0;
                                    lap_d = 1'b1;
                                end else begin
                                    pos_d = pos_q + PW'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    pos_d = POS_LAST;
                                    lap_d = 1'b1;
                                end else begin
                                    pos_d = pos_q - PW'(1);
                                end
                            end
`endif
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    led_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            count_q <= '0;
            pos_q   <= '0;
            rdir_q  <= 1'b0;
            led_q   <= '0;
            step_q  <= 1'b0;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pos_q   <= pos_d;
            rdir_q  <= rdir_d;
            led_q   <= led_d;
            step_q  <= step_d;
            lap_q   <= lap_d;
        end
    end

    assign LED_Out   = led_q;
    assign Busy      = (state_q != IDLE);
    assign Step_Done = step_q;
    assign Lap_Done  = lap_q;

endmodule

// File: tb/tb_led_run_ctrl.sv
// Directed bench for led_run_ctrl (N_LED=4, T_STEP=20, ON_START=15): vector table plus hand sequences.
module tb_led_run_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Start, Stop, Hold, Dir;
    logic [3:0] LED_Out;
    logic       Busy, Step_Done, Lap_Done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    led_run_ctrl #(
        .N_LED(4),
        .T_STEP(20),
        .ON_START(15)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .Start(Start),
        .Stop(Stop),
        .Hold(Hold),
        .Dir(Dir),
        .LED_Out(LED_Out),
        .Busy(Busy),
        .Step_Done(Step_Done),
        .Lap_Done(Lap_Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        start;
        logic        stop;
        logic        hold;
        logic        dir;
        int unsigned cyc;
        logic [3:0]  led;
        logic        busy;
        logic        step;
        logic        lap;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic p, input logic h, input logic d,
                       input int unsigned c, input logic [3:0] l,
                       input logic b, input logic st, input logic lp);
        vec_t v;
        v.start = s; v.stop = p; v.hold = h; v.dir = d; v.cyc = c;
        v.led = l; v.busy = b; v.step = st; v.lap = lp;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] l, input logic b,
                           input logic st, input logic lp);
        chk({nm, "_led"},  LED_Out,          l);
        chk({nm, "_busy"}, {3'b000, Busy},      {3'b000, b});
        chk({nm, "_step"}, {3'b000, Step_Done}, {3'b000, st});
        chk({nm, "_lap"},  {3'b000, Lap_Done},  {3'b000, lp});
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    logic [3:0] seq [8];
    logic       lap_exp [8];

    initial begin
        RST = 1'b1; Start = 1'b0; Stop = 1'b0; Hold = 1'b0; Dir = 1'b0;

        // Basic ascending run, with Dir toggled mid-run (must be ignored)
        add(1,0,0,0, 1, 4'b0000, 1,0,0);
        add(0,0,0,0,15, 4'b0000, 1,0,0);
        add(0,0,0,0, 1, 4'b0001, 1,0,0);
        add(0,0,0,0, 5, 4'b0001, 1,1,0);
        add(0,0,0,0, 1, 4'b0000, 1,0,0);
        add(0,0,0,0,15, 4'b0010, 1,0,0);
        add(0,0,0,0, 5, 4'b0010, 1,1,0);
        add(0,0,0,1, 1, 4'b0000, 1,0,0);
        add(0,0,0,1,41, 4'b1000, 1,1,1);
        add(0,0,0,1, 1, 4'b0000, 1,0,0);
        add(0,0,0,1,15, 4'b0001, 1,0,0);
        add(0,1,0,0, 1, 4'b0000, 0,0,0);
        add(0,0,0,0, 3, 4'b0000, 0,0,0);
        // Descending run with a Start while busy
        add(1,0,0,1, 1, 4'b0000, 1,0,0);
        add(1,0,0,0, 1, 4'b0000, 1,0,0);
        add(0,0,0,0,15, 4'b1000, 1,0,0);
        add(0,0,0,0, 5, 4'b1000, 1,1,0);
        add(0,0,0,0,16, 4'b0100, 1,0,0);
        add(0,0,0,0,21, 4'b0010, 1,0,0);
        add(0,0,0,0,21, 4'b0001, 1,0,0);
        add(0,0,0,0, 5, 4'b0001, 1,1,1);
        add(0,0,0,0,16, 4'b1000, 1,0,0);
        add(0,1,0,0, 1, 4'b0000, 0,0,0);
        add(0,0,0,0, 2, 4'b0000, 0,0,0);
        // Hold for 10 edges at Count=17: step done moves from edge 21 to 31
        add(1,0,0,0, 1, 4'b0000, 1,0,0);
        add(0,0,0,0,17, 4'b0001, 1,0,0);
        add(0,0,1,0, 1, 4'b0001, 1,0,0);
        add(0,0,1,0, 9, 4'b0001, 1,0,0);
        add(0,0,0,0, 2, 4'b0001, 1,0,0);
        add(0,0,0,0, 1, 4'b0001, 1,0,0);
        add(0,0,0,0, 1, 4'b0001, 1,1,0);
        add(0,0,0,0, 1, 4'b0000, 1,0,0);
        // Stop while held in the lit window
        add(0,0,0,0,15, 4'b0010, 1,0,0);
        add(0,0,1,0, 2, 4'b0010, 1,0,0);
        add(0,1,1,0, 1, 4'b0000, 0,0,0);
        add(0,0,0,0, 3, 4'b0000, 0,0,0);
        // Start and Stop together in IDLE
        add(1,1,0,0, 1, 4'b0000, 0,0,0);
        add(0,0,0,0,25, 4'b0000, 0,0,0);

        tick(2);
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            Start = vq[i].start; Stop = vq[i].stop; Hold = vq[i].hold; Dir = vq[i].dir;
            tick(vq[i].cyc);
            chk_all($sformatf("vec%0d", i), vq[i].led, vq[i].busy, vq[i].step, vq[i].lap);
        end
        Start = 1'b0; Stop = 1'b0; Hold = 1'b0; Dir = 1'b0;

        // Asynchronous reset mid-cycle inside the lit window
        Start = 1'b1; tick(1); Start = 1'b0;
        tick(17);
        chk("arst_pre_led", LED_Out, 4'b0001);
        #3 RST = 1'b1;
        #1;
        chk("arst_led", LED_Out, 4'b0000);
        chk("arst_busy", {3'b000, Busy}, 4'b0000);
        tick(1);
        RST = 1'b0;
        tick(5);
        chk("arst_idle_busy", {3'b000, Busy}, 4'b0000);
        chk("arst_idle_led", LED_Out, 4'b0000);
        Start = 1'b1; tick(1); Start = 1'b0;
        chk("arst_restart_busy", {3'b000, Busy}, 4'b0001);
        tick(16);
        chk("arst_restart_led", LED_Out, 4'b0001);

        // Eight consecutive advances from a fresh ascending start
        Stop = 1'b1; tick(1); Stop = 1'b0;
`ifdef LED_RUN_PINGPONG_EN
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        lap_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        lap_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        Start = 1'b1; Dir = 1'b0; tick(1); Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(21);
            chk_all($sformatf("lap%0d", i), seq[i], 1'b1, 1'b1, lap_exp[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_run_ctrl.md
# led_run_ctrl

Running-light sequencer for the LED board. It owns a step timer and a position register and walks a single lit LED across `N_LED` outputs. Within each step, the LED lights only during a programmable tail window. It sits between the board push-button/control logic and the LED pins, and it schedules which LED is driven and when.

## Interface
Parameters:
- `N_LED`, 4: number of LEDs driven; must be ≥ 2.
- `T_STEP`, 20: last value of the step counter; one step lasts `T_STEP+1` cycles.
- `ON_START`, 15: first counter value of the lit window; requires 0 < `ON_START` ≤ `T_STEP`.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `Start`  in  1  one-cycle request to begin a run; only honoured in IDLE.
- `Stop`  in  1  returns to IDLE on the next edge from any state.
- `Hold`  in  1  level input; freezes a run while high.
- `Dir`  in  1  direction, sampled only when Start is accepted: 0 = ascending index, 1 = descending.
- `LED_Out`  out  `N_LED`  one-hot (or zero) LED drive, registered.
- `Busy`  out  1  high in RUN or HOLD.
- `Step_Done`  out  1  one-cycle pulse when position advances.
- `Lap_Done`  out  1  one-cycle pulse when position wraps (or reverses, see Configuration).

## Operation
- Internal registers:
  - `Count`, width clog2(`T_STEP`+1).
  - `Pos`, width clog2(`N_LED`).
  - `rDir`.
  - `State` ∈ {IDLE, RUN, HOLD}.
- Input priority per edge: `Stop` > `Hold` > `Start`.
- IDLE behaviour:
  - `LED_Out`=0 and `Count`=0.
  - On `Start`, the block loads `Pos` = `Dir` ? `N_LED`-1 : 0, loads `rDir` = `Dir`, and goes to RUN.
- RUN behaviour:
  - `Count` increments each cycle.
  - When `Count`==`T_STEP`, `Count`→0 and `Pos` advances by ±1 according to `rDir`.
  - At the same edge, `Step_Done` pulses.
- Wrap rules:
  - Ascending from `N_LED`-1 goes to 0. Descending from 0 goes to `N_LED`-1.
  - A wrap also pulses `Lap_Done`, in the same cycle as `Step_Done`.
- RUN with `Hold`=1 → HOLD. In HOLD, `Count`, `Pos` and `LED_Out` are all frozen.
- HOLD with `Hold`=0 → RUN; counting resumes from the frozen `Count`.
- `Stop` in RUN or HOLD → IDLE. `LED_Out` goes to 0 on that edge and `Busy` goes to 0.
- `Start` in RUN or HOLD is ignored. `Start` and `Stop` in the same cycle: `Stop` wins.
- `LED_Out` update rule, each edge in RUN: `LED_Out` ← onehot(`Pos`) if `ON_START` ≤ `Count` ≤ `T_STEP`, else 0. The pre-edge values of `Count` and `Pos` are used.
- `Dir` changes during a run have no effect.

## Timing
- Reset values: `LED_Out`=0, `Busy`=0, `Step_Done`=0, `Lap_Done`=0, State=IDLE, `Count`=0, `Pos`=0. Reset acts immediately, without waiting for a clock edge.
- `Start` accepted at edge k: `Busy`=1 and `Count`=0 after edge k.
- `LED_Out` latency is one cycle behind the window:
  - The bit first goes high after edge k+`ON_START`+1.
  - The bit stays high for `T_STEP`-`ON_START`+1 cycles.
- `Pos` advances at edge k+`T_STEP`+1, then every `T_STEP`+1 cycles while not held.
- `Step_Done` and `Lap_Done` are registered outputs, high for exactly one cycle.
- Each HOLD cycle extends the current step by exactly one cycle.
- `Stop` takes effect at the next edge; no partial step is completed.

## Configuration
- Macro `LED_RUN_PINGPONG_EN`:
  - Defined: the block runs in bounce mode. When the position reaches an end (`N_LED`-1 ascending, 0 descending), `rDir` inverts on the advance edge. Position then moves back toward the other end and never wraps. `Lap_Done` pulses on each reversal.
  - Undefined: wrap behaviour as in Operation.

## Test plan
All scenarios use `N_LED`=4, `T_STEP`=20, `ON_START`=15.
- Basic run: Start at edge 0 with Dir=0 → `LED_Out`=0001 for edges 16–21, then 0. `Step_Done` after edge 21. `LED_Out`=0010 for edges 37–42. `Lap_Done` after edge 84.
- Descending run: Start with Dir=1 → lit sequence 1000, 0100, 0010, 0001, 1000. `Lap_Done` coincides with the 0001→1000 advance.
- Hold: raise Hold for 10 cycles while `LED_Out`=0001 at `Count`=17 → `LED_Out` stays 0001 throughout. The next `Step_Done` arrives 10 cycles later than nominal.
- Stop and ignored Start:
  - Start while Busy → no change.
  - Stop during HOLD → IDLE next edge, `LED_Out`=0, `Busy`=0.
  - Start and Stop together in IDLE → stays IDLE.
- Asynchronous reset: assert `RST` mid-cycle during the lit window → `LED_Out`=0 and `Busy`=0 before the next edge. After deassertion, the block stays IDLE until Start.
- Bounce mode (macro defined), Dir=0 → sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. `Lap_Done` on the 1000→0100 and 0001→0010 advances.
